// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control path.
// Contents: ALU control codes, ALUOp encodings, R-type funct codes,
// and the issuer FSM state type.
package alu_ctrl_pkg;

    localparam int unsigned CTRL_CODE_W = 4;

    // ALU control codes
    localparam logic [CTRL_CODE_W-1:0] CTRL_AND = 4'b0000;
    localparam logic [CTRL_CODE_W-1:0] CTRL_OR  = 4'b0001;
    localparam logic [CTRL_CODE_W-1:0] CTRL_ADD = 4'b0010;
    localparam logic [CTRL_CODE_W-1:0] CTRL_SUB = 4'b0110;
    localparam logic [CTRL_CODE_W-1:0] CTRL_SLT = 4'b0111;
    localparam logic [CTRL_CODE_W-1:0] CTRL_ILL = 4'b1111;

    // ALUOp encodings from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    // R-type funct field codes
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } issuer_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decoder (ALUOp + funct -> 4-bit ALU ctrl).
// Ports:
//   aluop_i   - 2-bit ALUOp: 00 add, 01 sub, 10 R-type, 11 illegal
//   funct_i   - 6-bit R-type funct field (used only for ALUOp 10)
//   ctrl_o    - ALU control code; CTRL_ILL for anything undecodable
//   illegal_o - high when the command did not decode
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0]             aluop_i,
    input  logic [5:0]             funct_i,
    output logic [CTRL_CODE_W-1:0] ctrl_o,
    output logic                   illegal_o
);

    always_comb begin
        ctrl_o    = CTRL_ILL;
        illegal_o = 1'b1;
        case (aluop_i)
            ALUOP_ADD: begin
                ctrl_o    = CTRL_ADD;
                illegal_o = 1'b0;
            end
            ALUOP_SUB: begin
                ctrl_o    = CTRL_SUB;
                illegal_o = 1'b0;
            end
            ALUOP_RTYPE: begin
                illegal_o = 1'b0;
                case (funct_i)
                    FUNCT_ADD: ctrl_o = CTRL_ADD;
                    FUNCT_SUB: ctrl_o = CTRL_SUB;
                    FUNCT_AND: ctrl_o = CTRL_AND;
                    FUNCT_OR:  ctrl_o = CTRL_OR;
                    FUNCT_SLT: ctrl_o = CTRL_SLT;
                    default: begin
                        ctrl_o    = CTRL_ILL;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl_o    = CTRL_ILL;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator side of the 32-bit ALU interface.
// Accepts a command over valid/ready, drives the combinational ALU for one
// EXEC cycle, captures result/zero and returns them over a valid/ready
// response channel. Counts completed responses.
// Ports:
//   clk_i, rst_i               - clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o    - command handshake
//   cmd_aluop_i, cmd_funct_i   - operation selection
//   cmd_src1_i, cmd_src2_i     - operands
//   alu_src1_o/src2_o/ctrl_o   - to ALU (held from latched registers)
//   alu_result_i, alu_zero_i   - from ALU
//   rsp_valid_o/rsp_ready_i    - response handshake
//   rsp_result_o, rsp_zero_o   - captured ALU outputs
//   rsp_illegal_o              - command did not decode
//   op_count_o                 - completed responses (wrapping)
module alu_cmd_issuer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_aluop_i,
    input  logic [5:0]        cmd_funct_i,
    input  logic [DATA_W-1:0] cmd_src1_i,
    input  logic [DATA_W-1:0] cmd_src2_i,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_zero_o,
    output logic              rsp_illegal_o,
    output logic [CNT_W-1:0]  op_count_o
);

    issuer_state_e state_q, state_d;

    logic [DATA_W-1:0]      src1_q, src2_q;
    logic [CTRL_W-1:0]      ctrl_q;
    logic                   ill_q;
    logic [DATA_W-1:0]      res_q;
    logic                   zero_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [CTRL_CODE_W-1:0] dec_ctrl;
    logic                   dec_ill;
    logic                   accept;
    logic                   capture;
    logic                   complete;

    alu_ctrl_decode u_decode (
        .aluop_i   (cmd_aluop_i),
        .funct_i   (cmd_funct_i),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_ill)
    );

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        complete    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                // Response drain and next-command accept share this cycle,
                // giving one op every two cycles when streaming.
                if (rsp_ready_i) begin
                    complete    = 1'b1;
                    cmd_ready_o = 1'b1;
                    if (cmd_valid_i) begin
                        accept  = 1'b1;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            src1_q  <= '0;
            src2_q  <= '0;
            ctrl_q  <= '0;
            ill_q   <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src1_q <= cmd_src1_i;
                src2_q <= cmd_src2_i;
                ctrl_q <= CTRL_W'(dec_ctrl);
                ill_q  <= dec_ill;
            end
            if (capture) begin
                res_q  <= alu_result_i;
                zero_q <= alu_zero_i;
            end
            if (complete) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign alu_src1_o    = src1_q;
    assign alu_src2_o    = src2_q;
    assign alu_ctrl_o    = ctrl_q;
    assign rsp_result_o  = res_q;
    assign rsp_zero_o    = zero_q;
    assign rsp_illegal_o = ill_q;
    assign op_count_o    = cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer paired with a behavioural ALU.
// Expected responses are queued when a command handshake is seen; a
// monitor pops and compares on every response handshake.
module tb_alu_cmd_issuer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_aluop_i;
    logic [5:0]        cmd_funct_i;
    logic [DATA_W-1:0] cmd_src1_i, cmd_src2_i;
    logic [DATA_W-1:0] alu_src1_o, alu_src2_o;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic [DATA_W-1:0] alu_result_i;
    logic              alu_zero_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_result_o;
    logic              rsp_zero_o;
    logic              rsp_illegal_o;
    logic [CNT_W-1:0]  op_count_o;

    always #5 clk = ~clk;

    alu_cmd_issuer #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_aluop_i   (cmd_aluop_i),
        .cmd_funct_i   (cmd_funct_i),
        .cmd_src1_i    (cmd_src1_i),
        .cmd_src2_i    (cmd_src2_i),
        .alu_src1_o    (alu_src1_o),
        .alu_src2_o    (alu_src2_o),
        .alu_ctrl_o    (alu_ctrl_o),
        .alu_result_i  (alu_result_i),
        .alu_zero_i    (alu_zero_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_result_o  (rsp_result_o),
        .rsp_zero_o    (rsp_zero_o),
        .rsp_illegal_o (rsp_illegal_o),
        .op_count_o    (op_count_o)
    );

    // Behavioural team ALU: slt is an unsigned compare, unknown codes give 0.
    always_comb begin
        case (alu_ctrl_o)
            4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
            4'b0001: alu_result_i = alu_src1_o | alu_src2_o;
            4'b0010: alu_result_i = alu_src1_o + alu_src2_o;
            4'b0110: alu_result_i = alu_src1_o - alu_src2_o;
            4'b0111: alu_result_i = {31'd0, alu_src1_o < alu_src2_o};
            default: alu_result_i = '0;
        endcase
        alu_zero_i = (alu_result_i == '0);
    end

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              zero;
        logic              ill;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    logic [CNT_W-1:0] mdl_cnt;
    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: operates directly on aluop/funct, independent of ctrl codes.
    function automatic exp_t ref_op(input logic [1:0] op, input logic [5:0] f,
                                    input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.ill = 1'b0;
        e.res = '0;
        if (op == 2'b00) e.res = a + b;
        else if (op == 2'b01) e.res = a - b;
        else if (op == 2'b10) begin
            if (f == 6'b100000) e.res = a + b;
            else if (f == 6'b100010) e.res = a - b;
            else if (f == 6'b100100) e.res = a & b;
            else if (f == 6'b100101) e.res = a | b;
            else if (f == 6'b101010) e.res = (a < b) ? 32'd1 : 32'd0;
            else e.ill = 1'b1;
        end else e.ill = 1'b1;
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Monitor: compares every response handshake against the scoreboard.
    initial begin
        mdl_cnt = '0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                sb_q.delete();
                mdl_cnt = '0;
            end else if (rsp_valid_o && rsp_ready_i) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got result 0x%0h with empty scoreboard", rsp_result_o);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("rsp_result", 64'(rsp_result_o), 64'(mon_e.res));
                    chk("rsp_zero", 64'(rsp_zero_o), 64'(mon_e.zero));
                    chk("rsp_illegal", 64'(rsp_illegal_o), 64'(mon_e.ill));
                    chk("op_count_at_rsp", 64'(op_count_o), 64'(mdl_cnt));
                    mdl_cnt = mdl_cnt + 1'b1;
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present a command; returns 1ns after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input logic [5:0] f,
                            input logic [31:0] a, input logic [31:0] b);
        bit ok = 0;
        cmd_valid_i = 1'b1;
        cmd_aluop_i = op;
        cmd_funct_i = f;
        cmd_src1_i  = a;
        cmd_src2_i  = b;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                sb_q.push_back(ref_op(op, f, a, b));
                ok = 1;
                sync();
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout: got cmd_ready 0 expected 1");
        end
        cmd_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) sync();
    endtask

    initial begin
        int t0;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a, b;
        logic [5:0]  functs [5];
        functs[0] = 6'b100000; functs[1] = 6'b100010; functs[2] = 6'b100100;
        functs[3] = 6'b100101; functs[4] = 6'b101010;

        rst_i = 1'b0; cmd_valid_i = 1'b0; cmd_aluop_i = '0; cmd_funct_i = '0;
        cmd_src1_i = '0; cmd_src2_i = '0; rsp_ready_i = 1'b1;
        idle(3);
        rst_i = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("rst_op_count", 64'(op_count_o), 64'd0);
        chk("rst_alu_ctrl", 64'(alu_ctrl_o), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result_o), 64'd0);
        chk("rst_rsp_illegal", 64'(rsp_illegal_o), 64'd0);
        sync();

        // 1: R-type add with latency check
        send_cmd(2'b10, 6'b100000, 32'd5, 32'd7);
        @(negedge clk);
        chk("t1_exec_valid", 64'(rsp_valid_o), 64'd0);
        chk("t1_exec_ctrl", 64'(alu_ctrl_o), 64'h2);
        chk("t1_exec_src1", 64'(alu_src1_o), 64'd5);
        chk("t1_exec_cmd_ready", 64'(cmd_ready_o), 64'd0);
        @(negedge clk);
        chk("t1_resp_valid", 64'(rsp_valid_o), 64'd1);
        @(negedge clk);
        chk("t1_op_count", 64'(op_count_o), 64'd1);
        chk("t1_idle_valid", 64'(rsp_valid_o), 64'd0);
        sync();

        // 2: sub giving zero, slt
        send_cmd(2'b01, 6'b000000, 32'h1234, 32'h1234);
        send_cmd(2'b10, 6'b101010, 32'd3, 32'd9);
        idle(3);

        // 3: illegal ops still complete
        send_cmd(2'b11, 6'b100000, 32'd5, 32'd7);
        @(negedge clk);
        chk("t3_ctrl_aluop11", 64'(alu_ctrl_o), 64'hF);
        sync();
        send_cmd(2'b10, 6'b000000, 32'd8, 32'd8);
        @(negedge clk);
        chk("t3_ctrl_funct0", 64'(alu_ctrl_o), 64'hF);
        sync();
        idle(3);
        @(negedge clk);
        chk("t3_op_count", 64'(op_count_o), 64'd5);
        sync();

        // 4: backpressure, then same-cycle accept
        rsp_ready_i = 1'b0;
        send_cmd(2'b00, 6'b000000, 32'd100, 32'd23);
        cmd_valid_i = 1'b1; cmd_aluop_i = 2'b10; cmd_funct_i = 6'b100010;
        cmd_src1_i = 32'd50; cmd_src2_i = 32'd8;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(rsp_valid_o), 64'd1);
            chk("t4_hold_result", 64'(rsp_result_o), 64'd123);
            chk("t4_hold_cmd_ready", 64'(cmd_ready_o), 64'd0);
        end
        sync();
        rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("t4_same_cycle_ready", 64'(cmd_ready_o), 64'd1);
        if (cmd_ready_o) sb_q.push_back(ref_op(2'b10, 6'b100010, 32'd50, 32'd8));
        sync();
        cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("t4_next_exec_valid", 64'(rsp_valid_o), 64'd0);
        @(negedge clk);
        chk("t4_next_rsp_valid", 64'(rsp_valid_o), 64'd1);
        sync();
        idle(2);

        // 5: reset during EXEC drops the op
        send_cmd(2'b00, 6'b000000, 32'd1, 32'd2);
        rst_i = 1'b0;
        sync();
        rst_i = 1'b1;
        @(negedge clk);
        chk("t5_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("t5_op_count", 64'(op_count_o), 64'd0);
        chk("t5_cmd_ready", 64'(cmd_ready_o), 64'd1);
        sync();
        idle(6);

        // 6: back-to-back stream of 300 ops
        t0 = cyc;
        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            fn = 6'b000000;
            case ($urandom_range(0, 7))
                0: op = 2'b00;
                1: op = 2'b01;
                7: begin op = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b10; fn = 6'b000111; end
                default: begin op = 2'b10; fn = functs[$urandom_range(0, 4)]; end
            endcase
            send_cmd(op, fn, a, b);
        end
        chk("t6_throughput", 64'((cyc - t0) <= 600), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !rsp_valid_o) break;
        end
        chk("t6_drained", 64'(sb_q.size()), 64'd0);
        chk("t6_op_count_wrap", 64'(op_count_o), 64'd44);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
